// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: 8x8 column-strobed scan, per-key debounce, 4-deep event FIFO.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [7:0]      col_drive,
    input  logic [7:0]      row_sense,
    output logic [7:0][7:0] key_state,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [5:0]      evt_code,
    output logic            evt_press
);

    localparam int unsigned CW         = $clog2(SCAN_DIV);
    localparam int unsigned NKEYS      = 64;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned EW         = 7;

    // scan timing and sampling state
    logic [CW-1:0]     pre_q;
    logic [2:0]        col_q;
    logic [2:0]        col_nxt;
    logic [7:0]        col_drive_q;
    logic [7:0]        sync1_q;
    logic [7:0]        sync2_q;
    logic [7:0]        sample_q;
    logic [2:0]        sample_col_q;
    logic              sample_valid_q;
    logic              pre_wrap;

    // debounce and event state
    logic [7:0][7:0]   key_state_q;
    logic [2:0]        dcnt_q [NKEYS];
    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [2:0]        count_q;
    logic              valid_q;

    // evaluation and FIFO next-state signals
    logic              eval_en;
    logic [2:0]        eval_row;
    logic [5:0]        eval_key;
    logic              raw_bit;
    logic              stable_bit;
    logic [2:0]        cur_cnt;
    logic [2:0]        dcnt_nxt;
    logic              flip_req;
    logic              pop;
    logic              push_ok;
    logic              push;
    logic [1:0]        wr_idx;
    logic [EW-1:0]     fifo_nxt [FIFO_DEPTH];
    logic [2:0]        count_nxt;

    assign pre_wrap = (pre_q == CW'(SCAN_DIV - 1));
    assign col_nxt  = col_q + 3'd1;

    // prescaler, column strobe, row synchronizer and end-of-dwell sample
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q          <= '0;
            col_q          <= '0;
            col_drive_q    <= 8'hFE;
            sync1_q        <= 8'hFF;
            sync2_q        <= 8'hFF;
            sample_q       <= '0;
            sample_col_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sync1_q <= row_sense;
            sync2_q <= sync1_q;
            if (pre_wrap) begin
                pre_q          <= '0;
                col_q          <= col_nxt;
                col_drive_q    <= ~(8'(1) << col_nxt);
                sample_q       <= ~sync2_q;
                sample_col_q   <= col_q;
                sample_valid_q <= 1'b1;
            end else begin
                pre_q <= pre_q + CW'(1);
            end
        end
    end

    // one-row-per-clock debounce evaluation and FIFO next state
    always_comb begin
        eval_en    = sample_valid_q && (pre_q < CW'(8));
        eval_row   = pre_q[2:0];
        eval_key   = {sample_col_q, eval_row};
        raw_bit    = sample_q[eval_row];
        stable_bit = key_state_q[sample_col_q][eval_row];
        cur_cnt    = dcnt_q[eval_key];
        pop        = valid_q && evt_ready;
        push_ok    = (count_q < 3'(FIFO_DEPTH)) || pop;
        flip_req   = eval_en && (raw_bit != stable_bit) && (cur_cnt == 3'(DEBOUNCE - 1));
        push       = flip_req && push_ok;

        dcnt_nxt = cur_cnt;
        if (raw_bit == stable_bit) begin
            dcnt_nxt = '0;
        end else if (flip_req) begin
            // a blocked flip parks just below the threshold and retries next scan
            dcnt_nxt = push ? 3'd0 : 3'(DEBOUNCE - 1);
        end else begin
            dcnt_nxt = cur_cnt + 3'd1;
        end

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_nxt[i] = fifo_q[i];
        end
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_nxt[i] = fifo_q[i+1];
            end
            fifo_nxt[FIFO_DEPTH-1] = '0;
        end
        wr_idx = 2'(pop ? (count_q - 3'd1) : count_q);
        if (push) begin
            fifo_nxt[wr_idx] = {eval_key, ~stable_bit};
        end
        count_nxt = count_q + 3'(push) - 3'(pop);
    end

    // debounce counters, stable key map and shift-register event FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            key_state_q <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                dcnt_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (eval_en) begin
                dcnt_q[eval_key] <= dcnt_nxt;
            end
            if (push) begin
                key_state_q[sample_col_q][eval_row] <= ~stable_bit;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_nxt[i];
            end
            count_q <= count_nxt;
            valid_q <= (count_nxt != 3'd0);
        end
    end

    assign col_drive = col_drive_q;
    assign key_state = key_state_q;
    assign evt_valid = valid_q;
    assign evt_code  = fifo_q[0][EW-1:1];
    assign evt_press = fifo_q[0][0];

endmodule

// File: doc/keypad_matrix_scanner.md
KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clocks per column dwell; legal range 10..256.
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive differing scans needed to change a key's stable state; legal range 1..7.
REQ-003 clk  input  1  system clock; all state on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 col_drive  output  8  one-cold column strobe, active-low; bit c low while column c is scanned.
REQ-006 row_sense  input  8  asynchronous row returns, active-low; bit r low means key (c,r) pressed under the active column.
REQ-007 key_state  output  [7:0][7:0]  debounced stable map; key_state[c][r]=1 means pressed.
REQ-008 evt_valid  output  1  event FIFO head valid.
REQ-009 evt_ready  input  1  consumer accepts head when high with evt_valid.
REQ-010 evt_code  output  6  head key code {col[2:0], row[2:0]}.
REQ-011 evt_press  output  1  head event type: 1 press, 0 release.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; column index SHALL advance 0..7 at wrap, then return to 0; one full scan = 8*SCAN_DIV clocks.
REQ-013 col_drive SHALL be ~(8'b1 << col), registered-state derived, with no glitch-free requirement beyond being one-cold every cycle.
REQ-014 row_sense SHALL pass a 2-flop synchronizer; the synchronizer output, inverted, SHALL be latched as the raw sample when the prescaler equals SCAN_DIV-1, tagged with the current column.
REQ-015 The latched sample SHALL be evaluated one row per clock during prescaler values 0..7 of the next dwell, row r at value r.
REQ-016 Evaluating key k: raw == stable -> counter[k] cleared; raw != stable -> counter[k] incremented; reaching DEBOUNCE -> flip requested.
REQ-017 A flip request SHALL push one event {code, new state} and, in the same cycle, toggle key_state[k] and clear counter[k].
REQ-018 Event FIFO SHALL be 4 entries, in order; push permitted when occupancy < 4 or a pop occurs in the same cycle.
REQ-019 Flip request with push not permitted: key_state[k] unchanged, counter[k] held at DEBOUNCE-1; retried on the next scan of that key; no event is ever lost or duplicated.
REQ-020 evt_valid SHALL equal FIFO non-empty; pop when evt_valid && evt_ready; evt_code/evt_press SHALL hold stable while evt_valid && !evt_ready.
REQ-021 Simultaneous push and pop on empty FIFO: pushed entry appears at head next cycle (no bypass; evt_valid rises one clock after push).
REQ-022 Latency, clean press on key (c,r): event visible no later than DEBOUNCE*8*SCAN_DIV + SCAN_DIV + 11 clocks after row_sense edge.
REQ-023 Column 7 sample SHALL be evaluated in column 0's dwell (wrap-around).

Reset
REQ-024 During reset: prescaler 0, col 0, col_drive 8'hFE, synchronizer flops 8'hFF, sample register invalid (no evaluation in the first dwell after reset).
REQ-025 During reset: key_state all 0, all counters 0, FIFO empty, evt_valid 0, evt_code 0, evt_press 0.
REQ-026 Reset mid-operation SHALL discard queued events; keys still held SHALL re-emit press events after DEBOUNCE scans.

Verification (SCAN_DIV=16, DEBOUNCE=4)
REQ-027 Reset, no keys -> col_drive 8'hFE; 8'hFD at clock 16; back to 8'hFE at clock 128; evt_valid stays 0 for 2000 clocks.
REQ-028 Hold key (2,5), evt_ready=1 -> exactly one event, evt_code 6'd21, evt_press 1, key_state[2][5]=1 within 4 scans + 27 clocks; release -> one event 6'd21, evt_press 0.
REQ-029 Key (4,1) pressed for exactly 3 scans then released -> no event, key_state stays 0.
REQ-030 evt_ready=0, hold six keys in column 3 -> evt_valid=1, FIFO fills with 4 events, key_state shows only those 4; set evt_ready=1 -> remaining 2 events delivered on following scans, 6 total, in row order.
REQ-031 Press (0,0) and (7,7) simultaneously -> both events delivered, (7,7) evaluated in column 0 dwell, no duplicates.
REQ-032 Assert reset while key (5,5) held with 2 events queued -> evt_valid 0 and key_state 0 next cycle; one press event 6'd45 after 4 scans.
